// File: rtl/gray_conv_arbiter_if.sv
// gray_conv_arbiter_if: request/result bus between requesters, the shared Gray converter and its consumer.
interface gray_conv_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int TAGW  = 2,
  parameter int CNTW  = 16
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_mode;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [TAGW-1:0]       out_tag;
  logic                  out_mode;
  logic [CNTW-1:0]       conv_count;
  logic                  busy;
  modport master (
    output req_valid, req_data, req_mode, out_ready,
    input  req_ready, out_valid, out_data, out_tag, out_mode, conv_count, busy
  );
  modport slave (
    input  req_valid, req_data, req_mode, out_ready,
    output req_ready, out_valid, out_data, out_tag, out_mode, conv_count, busy
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin shared bin<->Gray converter with one registered, tagged result stage.
module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int TAGW  = 2,
  parameter int CNTW  = 16
) (
  input logic clk,
  input logic rst,
  gray_conv_arbiter_if.slave bus
);
  logic [TAGW-1:0]  rr_ptr, win;
  logic             found, can_accept, grant;
  logic             out_valid, out_mode;
  logic [WIDTH-1:0] out_data;
  logic [TAGW-1:0]  out_tag;
  logic [CNTW-1:0]  conv_count;

  function automatic logic [WIDTH-1:0] conv(input logic [WIDTH-1:0] d, input logic m);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = d[WIDTH-1];
    for (int k = WIDTH-2; k >= 0; k--) b[k] = b[k+1] ^ d[k];
    return m ? b : d ^ (d >> 1);
  endfunction

  // Scan from the farthest offset down so the nearest valid requester to rr_ptr wins.
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = NREQ-1; k >= 0; k--)
      if (bus.req_valid[rr_ptr + TAGW'(k)]) begin
        win = rr_ptr + TAGW'(k);
        found = 1'b1;
      end
  end

  assign can_accept    = !out_valid || bus.out_ready;
  assign grant         = found && can_accept && !rst;
  assign bus.req_ready = grant ? NREQ'(1) << win : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      out_mode   <= 1'b0;
      conv_count <= '0;
      rr_ptr     <= '0;
    end else begin
      if (grant) begin
        out_data  <= conv(bus.req_data[win*WIDTH +: WIDTH], bus.req_mode[win]);
        out_tag   <= win;
        out_mode  <= bus.req_mode[win];
        out_valid <= 1'b1;
        rr_ptr    <= win + TAGW'(1);
      end else if (bus.out_ready) out_valid <= 1'b0;
      if (out_valid && bus.out_ready) conv_count <= conv_count + 1'b1;
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.out_tag    = out_tag;
  assign bus.out_mode   = out_mode;
  assign bus.conv_count = conv_count;
  assign bus.busy       = out_valid || |bus.req_valid;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed stimulus, per-cycle comparison against a behavioural model plus literal pins.
module tb_gray_conv_arbiter;
  localparam int W = 4, NREQ = 4, TAGW = 2, CNTW = 16;
  logic clk = 1'b0;
  logic rst;
  int total = 0, bad = 0;
  gray_conv_arbiter_if #(.WIDTH(W), .NREQ(NREQ), .TAGW(TAGW), .CNTW(CNTW)) bus ();
  gray_conv_arbiter #(.WIDTH(W), .NREQ(NREQ), .TAGW(TAGW), .CNTW(CNTW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic            m_valid, m_mode;
  logic [W-1:0]    m_data;
  int              m_tag, m_ptr;
  logic [CNTW-1:0] m_cnt;
  logic [W-1:0]    garr [16];
  logic [W-1:0]    hold;
  logic [CNTW-1:0] c0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_win(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[(ptr+k)%NREQ]) return (ptr+k)%NREQ;
    return -1;
  endfunction

  // Gray->binary as the XOR of every right shift of the code.
  function automatic logic [W-1:0] m_conv(input logic [W-1:0] d, input logic m);
    logic [W-1:0] b;
    if (!m) return d ^ (d >> 1);
    b = d;
    for (int s = 1; s < W; s++) b = b ^ (d >> s);
    return b;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    int w;
    r = '0;
    w = m_win(m_ptr, bus.req_valid);
    if (w >= 0 && (!m_valid || bus.out_ready)) r[w] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_data <= '0; m_tag <= 0; m_mode <= 1'b0; m_cnt <= '0; m_ptr <= 0;
    end else begin
      if (m_valid && bus.out_ready) m_cnt <= m_cnt + 1'b1;
      if (m_win(m_ptr, bus.req_valid) >= 0 && (!m_valid || bus.out_ready)) begin
        m_data  <= m_conv(bus.req_data[m_win(m_ptr, bus.req_valid)*W +: W], bus.req_mode[m_win(m_ptr, bus.req_valid)]);
        m_tag   <= m_win(m_ptr, bus.req_valid);
        m_mode  <= bus.req_mode[m_win(m_ptr, bus.req_valid)];
        m_valid <= 1'b1;
        m_ptr   <= (m_win(m_ptr, bus.req_valid) + 1) % NREQ;
      end else if (bus.out_ready) m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("req_ready", bus.req_ready, exp_ready());
      chk("out_valid", bus.out_valid, m_valid);
      chk("out_data", bus.out_data, m_data);
      chk("out_tag", bus.out_tag, m_tag);
      chk("out_mode", bus.out_mode, m_mode);
      chk("conv_count", bus.conv_count, m_cnt);
      chk("busy", bus.busy, m_valid || |bus.req_valid);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data = '0;
    bus.req_mode = '0;
    bus.out_ready = 1'b0;
    chk("pin_b2g_7", m_conv(4'b0111, 1'b0), 4'b0100);
    chk("pin_g2b_4", m_conv(4'b0100, 1'b1), 4'b0111);
    chk("pin_g2b_f", m_conv(4'b1111, 1'b1), 4'b1010);
    @(negedge clk); #1;
    chk("rst_ready", bus.req_ready, 4'b0000);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_count", bus.conv_count, 16'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    // mode coverage on requester 0
    bus.req_valid = 4'b0001; bus.req_data[3:0] = 4'b0111; bus.req_mode[0] = 1'b0; bus.out_ready = 1'b1;
    #1 chk("mode0_ready", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_data[3:0] = 4'b0100; bus.req_mode[0] = 1'b1;
    #1;
    chk("mode0_valid", bus.out_valid, 1'b1);
    chk("mode0_data", bus.out_data, 4'b0100);
    chk("mode0_tag", bus.out_tag, 2'd0);
    chk("mode0_mode", bus.out_mode, 1'b0);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("mode1_data", bus.out_data, 4'b0111);
    chk("mode1_mode", bus.out_mode, 1'b1);
    // exhaustive sweep through requester 2, then round trip
    do_reset();
    bus.out_ready = 1'b1;
    for (int x = 0; x < 16; x++) begin
      bus.req_valid = 4'b0100; bus.req_data[11:8] = 4'(x); bus.req_mode[2] = 1'b0;
      @(negedge clk); #1;
      garr[x] = bus.out_data;
    end
    for (int x = 0; x < 16; x++) begin
      bus.req_valid = 4'b0100; bus.req_data[11:8] = garr[x]; bus.req_mode[2] = 1'b1;
      @(negedge clk); #1;
      chk("roundtrip", bus.out_data, 32'(x));
    end
    bus.req_valid = '0;
    @(negedge clk); #1;
    chk("sweep_count", bus.conv_count, 16'd32);
    // round-robin with all requesters held valid
    do_reset();
    bus.req_data = 16'hd953; bus.req_mode = 4'b0101; bus.req_valid = 4'b1111; bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      chk("rr_tag", bus.out_tag, 32'(k % NREQ));
    end
    // backpressure with requester 1 pending
    bus.req_valid = 4'b0010; bus.out_ready = 1'b0;
    hold = bus.out_data; c0 = bus.conv_count;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_data", bus.out_data, hold);
      chk("bp_tag", bus.out_tag, 2'd1);
      chk("bp_ready", bus.req_ready, 4'b0000);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", bus.req_ready, 4'b0010);
    @(negedge clk); #1;
    chk("bp_drain_valid", bus.out_valid, 1'b1);
    chk("bp_drain_count", bus.conv_count, c0 + 1'b1);
    // fairness after skip, pointer now at 2
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("skip_tag", bus.out_tag, (k % 2 == 0) ? 32'd3 : 32'd1);
    end
    // asynchronous reset between edges
    do_reset();
    bus.req_valid = 4'b0001; bus.req_data[3:0] = 4'b1001; bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("pre_rst_count", bus.conv_count, 16'd5);
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    #2 rst = 1'b1;
    bus.req_valid = 4'b0101;
    #1;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_data", bus.out_data, 4'b0000);
    chk("arst_count", bus.conv_count, 16'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1 chk("post_rst_ready", bus.req_ready, 4'b0001);
    @(negedge clk); #1;
    chk("post_rst_tag", bus.out_tag, 2'd0);
    chk("post_rst_valid", bus.out_valid, 1'b1);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    #3 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
Shares one 4-bit Gray-code conversion datapath among NREQ requesters. Each conversion is either binary-to-Gray or Gray-to-binary. The block arbitrates round-robin between requesters using valid/ready handshakes. It computes the result in a single registered stage, tags it with the winning requester index, and holds it until the consumer accepts it. It sits between the requesting blocks and whichever block consumes the converted codes.

Parameters:
WIDTH, 4, data width of codes converted (>=2)
NREQ, 4, number of requesters (fixed power of two, 2..8)
TAGW, 2, log2(NREQ); width of requester tag
CNTW, 16, width of completed-conversion counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  NREQ  per-requester request valid
req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
req_mode  input  NREQ  per-requester mode: 0 = bin->gray, 1 = gray->bin
req_ready  output  NREQ  one-hot grant/accept; at most one bit high
out_valid  output  1  result register holds valid result
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  converted code
out_tag  output  TAGW  index of requester that produced out_data
out_mode  output  1  mode used for out_data
conv_count  output  CNTW  number of completed output handshakes
busy  output  1  out_valid OR any req_valid

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_tag=0, out_mode=0, conv_count=0, rr_ptr=0. req_ready is all-zero while rst=1.
- can_accept = !out_valid || out_ready (the output register is empty or is being drained this cycle).
- Arbitration (combinational):
  - Scan requesters starting at rr_ptr, ascending, wrapping modulo NREQ.
  - The first i with req_valid[i]=1 wins.
  - req_ready[i]=1 only for the winner, and only when can_accept=1.
  - req_ready does not depend on any other req_ready, so there is no combinational loop.
- Accept (req_valid[i] && req_ready[i] at a rising edge):
  - out_data <= conv(req_data[i], req_mode[i]).
  - out_tag <= i; out_mode <= req_mode[i]; out_valid <= 1.
  - rr_ptr <= (i+1) mod NREQ.
- Latency: exactly 1 cycle from accept to out_valid.
- Full throughput (one result per cycle) is sustained while out_ready=1.
- Conversion:
  - bin->gray: G = B ^ (B >> 1).
  - gray->bin: B[WIDTH-1] = G[WIDTH-1]; B[k] = B[k+1] ^ G[k] for k down to 0.
  - Pure XOR; no carries; result is always WIDTH bits.
- Output drain:
  - If out_valid && out_ready and no new accept in the same cycle: out_valid <= 0. out_data, out_tag and out_mode retain their values.
  - Simultaneous drain and accept: the new result replaces the old one and out_valid stays 1.
- Backpressure: while out_valid && !out_ready, out_data, out_tag and out_mode are stable, req_ready is all-zero and rr_ptr is unchanged.
- Requester rule: once req_valid[i] is raised it must stay high, with data and mode stable, until req_ready[i]. The block does not check this rule.
- Idle requesters: a requester not granted keeps waiting. Round-robin guarantees a grant within NREQ accepts.
- rr_ptr advances only on an accept, never on idle cycles.
- conv_count increments on every out_valid && out_ready and wraps from 2^CNTW-1 to 0.
- Reset mid-operation: a pending result is discarded (out_valid=0) and the counter clears. After rst deasserts, arbitration restarts at requester 0 on the first rising edge.

Test Plan:
- Mode coverage: req0 valid, mode 0, data 4'b0111, out_ready=1 -> req_ready=4'b0001 in the same cycle; next cycle out_valid=1, out_data=4'b0100, out_tag=0, out_mode=0. Repeat with mode 1, data 4'b0100 -> out_data=4'b0111.
- Exhaustive: sweep all 16 values in both modes through req2 -> every result matches the formulas. gray->bin(bin->gray(x))==x for all x; conv_count=32 at the end.
- Round-robin: all four requesters held valid, out_ready=1 -> out_tag sequence 0,1,2,3,0,1 on consecutive cycles; req_ready is one-hot each cycle.
- Backpressure: out_valid=1 with out_ready=0 for 5 cycles -> out_data, out_tag and out_mode are constant and req_ready=0. Raising out_ready with req1 pending -> drain and accept in the same edge; out_valid stays 1 and conv_count increments by 1.
- Fairness after skip: only req3 and req1 valid, rr_ptr=2 -> grant order 3,1,3,1.
- Async reset: assert rst between clock edges while out_valid=1 and conv_count=5 -> out_valid, out_data and conv_count go to 0 immediately with no clock edge. After release, requesters 0 and 2 valid -> first grant to 0.
